// File: rtl/prod_accum_pkg.sv
// Shared types and constants for the prod_accum multiply-accumulate back end.
package prod_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  localparam int PROD_W = 8;
  localparam int NIB_W  = 4;

endpackage

// File: rtl/prod_accum_add.sv
// Accumulator adder with carry out; saturates to all-ones on carry when
// PROD_ACCUM_SAT_EN is defined, otherwise wraps modulo 2^ACC_W.
module prod_accum_add
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full;

  assign full    = {1'b0, acc_i} + {{(ACC_W+1-PROD_W){1'b0}}, prod_i};
  assign carry_o = full[ACC_W];

  // Once saturated, any further nonzero addend carries again, so the
  // all-ones value holds for the rest of the batch without extra state.
  always_comb begin
`ifdef PROD_ACCUM_SAT_EN
    sum_o = carry_o ? '1 : full[ACC_W-1:0];
`else
    sum_o = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/prod_accum.sv
// Sequential MAC back end: sums COUNT products per batch, presents the result
// on a valid/ready handshake. Saturation selected by PROD_ACCUM_SAT_EN.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = 10,
  parameter int COUNT = 4,
  parameter int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NIB_W-1:0] prod_lo,
  input  logic [NIB_W-1:0] prod_hi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [CNT_W-1:0] cnt
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  sum;
  logic              carry;

  assign prod = {prod_hi, prod_lo};

  prod_accum_add #(.ACC_W(ACC_W)) u_add (
    .acc_i   (acc_q),
    .prod_i  (prod),
    .sum_o   (sum),
    .carry_o (carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_d = sum;
            ovf_d = ovf_q | carry;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(COUNT - 1)) state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed, table-driven bench for prod_accum (default instance) plus an
// ACC_W=8/COUNT=2 instance for overflow; expectations follow PROD_ACCUM_SAT_EN.
module tb_prod_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       clr0 = 1'b0, vld0 = 1'b0, ordy0 = 1'b0;
  logic [7:0] p0 = '0;
  logic       irdy0, ovalid0, ovf0;
  logic [9:0] acc0;
  logic [2:0] cnt0;

  logic       clr1 = 1'b0, vld1 = 1'b0, ordy1 = 1'b0;
  logic [7:0] p1 = '0;
  logic       irdy1, ovalid1, ovf1;
  logic [7:0] acc1;
  logic [1:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prod_accum u0 (
    .clk(clk), .rst(rst), .clr(clr0),
    .in_valid(vld0), .in_ready(irdy0),
    .prod_lo(p0[3:0]), .prod_hi(p0[7:4]),
    .out_valid(ovalid0), .out_ready(ordy0),
    .acc_out(acc0), .ovf(ovf0), .cnt(cnt0)
  );

  prod_accum #(.ACC_W(8), .COUNT(2)) u1 (
    .clk(clk), .rst(rst), .clr(clr1),
    .in_valid(vld1), .in_ready(irdy1),
    .prod_lo(p1[3:0]), .prod_hi(p1[7:4]),
    .out_valid(ovalid1), .out_ready(ordy1),
    .acc_out(acc1), .ovf(ovf1), .cnt(cnt1)
  );

  typedef struct {
    logic       vld;
    logic [7:0] p;
    logic       clr;
    logic       ordy;
    logic [9:0] acc;
    logic       ovf;
    logic [2:0] cnt;
    logic       ov;
    logic       ir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vld, logic [7:0] p, logic clr, logic ordy,
                              logic [9:0] acc, logic ovf, logic [2:0] cnt,
                              logic ov, logic ir);
    vec_t v;
    v.vld = vld; v.p = p; v.clr = clr; v.ordy = ordy;
    v.acc = acc; v.ovf = ovf; v.cnt = cnt; v.ov = ov; v.ir = ir;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check0(input string tag, input logic [9:0] acc, input logic ovf,
                        input logic [2:0] cnt, input logic ov, input logic ir);
    check({tag, ".acc"},       32'(acc0),    32'(acc));
    check({tag, ".ovf"},       32'(ovf0),    32'(ovf));
    check({tag, ".cnt"},       32'(cnt0),    32'(cnt));
    check({tag, ".out_valid"}, 32'(ovalid0), 32'(ov));
    check({tag, ".in_ready"},  32'(irdy0),   32'(ir));
  endtask

  logic [9:0] model_sum;

  initial begin
    // 15*15 = 0xE1 four times, out_ready high
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(1'b1, 8'hE1, 1'b0, 1'b1, 10'(225 * i), 1'b0, 3'(i), i == 4, i != 4));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 10'd0, 1'b0, 3'd0, 1'b0, 1'b1));
    // Backpressure: 9, 21, 16, 0 with out_ready low
    tbl.push_back(mk(1'b1, 8'd9,  1'b0, 1'b0, 10'd9,  1'b0, 3'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'd21, 1'b0, 1'b0, 10'd30, 1'b0, 3'd2, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'd16, 1'b0, 1'b0, 10'd46, 1'b0, 3'd3, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'd0,  1'b0, 1'b0, 10'd46, 1'b0, 3'd4, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 10'd46, 1'b0, 3'd4, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 10'd0, 1'b0, 3'd0, 1'b0, 1'b1));
    // clr mid-batch drops the simultaneous product
    tbl.push_back(mk(1'b1, 8'd5,  1'b0, 1'b0, 10'd5,  1'b0, 3'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'd10, 1'b0, 1'b0, 10'd15, 1'b0, 3'd2, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'd15, 1'b1, 1'b0, 10'd0,  1'b0, 3'd0, 1'b0, 1'b1));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(1'b1, 8'd5, 1'b0, 1'b0, 10'(5 * i), 1'b0, 3'(i), i == 4, i != 4));
    // clr while DONE beats a simultaneous out handshake
    tbl.push_back(mk(1'b0, 8'd0, 1'b1, 1'b1, 10'd0, 1'b0, 3'd0, 1'b0, 1'b1));

    // Reset state
    #3;
    check("rst.acc",       32'(acc0),    32'd0);
    check("rst.cnt",       32'(cnt0),    32'd0);
    check("rst.ovf",       32'(ovf0),    32'd0);
    check("rst.out_valid", 32'(ovalid0), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rst.in_ready", 32'(irdy0), 32'd1);

    foreach (tbl[k]) begin
      vld0 = tbl[k].vld; p0 = tbl[k].p; clr0 = tbl[k].clr; ordy0 = tbl[k].ordy;
      step();
      check0($sformatf("vec%0d", k), tbl[k].acc, tbl[k].ovf, tbl[k].cnt, tbl[k].ov, tbl[k].ir);
    end
    vld0 = 1'b0; clr0 = 1'b0; ordy0 = 1'b1;

    // Sweep a=0..15, b=5, batches of 4 -> 30, 110, 190, 270
    model_sum = '0;
    for (int a = 0; a < 16; a++) begin
      vld0 = 1'b1; p0 = 8'(a * 5);
      model_sum = model_sum + 10'(a * 5);
      step();
      if (a % 4 == 3) begin
        vld0 = 1'b0;
        check0($sformatf("sweep%0d", a / 4), model_sum, 1'b0, 3'd4, 1'b1, 1'b0);
        check($sformatf("sweep%0d.table", a / 4), 32'(acc0), 32'(30 + 80 * (a / 4)));
        step();
        check($sformatf("sweep%0d.ret", a / 4), 32'(acc0), 32'd0);
        model_sum = '0;
      end
    end
    vld0 = 1'b0;

    // Overflow on 8-bit, COUNT=2 instance: 225 + 225
    vld1 = 1'b1; p1 = 8'd225; ordy1 = 1'b0;
    step();
    check("ovf.acc1", 32'(acc1), 32'd225);
    check("ovf.ovf1", 32'(ovf1), 32'd0);
    step();
    vld1 = 1'b0;
`ifdef PROD_ACCUM_SAT_EN
    check("ovf.acc2", 32'(acc1), 32'd255);
`else
    check("ovf.acc2", 32'(acc1), 32'd194);
`endif
    check("ovf.ovf2",  32'(ovf1),    32'd1);
    check("ovf.cnt2",  32'(cnt1),    32'd2);
    check("ovf.valid", 32'(ovalid1), 32'd1);
    ordy1 = 1'b1;
    step();
    check("ovf.clr_acc", 32'(acc1), 32'd0);
    check("ovf.clr_ovf", 32'(ovf1), 32'd0);
    ordy1 = 1'b0;

    // Async reset while DONE, between clock edges
    ordy0 = 1'b0; vld0 = 1'b1; p0 = 8'd1;
    for (int i = 0; i < 4; i++) step();
    vld0 = 1'b0;
    check("arst.pre_valid", 32'(ovalid0), 32'd1);
    check("arst.pre_acc",   32'(acc0),    32'd4);
    #2 rst = 1'b1;
    #1;
    check("arst.valid", 32'(ovalid0), 32'd0);
    check("arst.acc",   32'(acc0),    32'd0);
    check("arst.cnt",   32'(cnt0),    32'd0);
    #1 rst = 1'b0;
    step();
    check("arst.in_ready", 32'(irdy0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Sequential multiply-accumulate back end that sits directly downstream of the 4x4 multiplier.
- Takes the split 8-bit product (prod_hi:prod_lo) under a valid/ready handshake and sums COUNT products into an accumulator.
- Presents each batch sum, plus an overflow flag, on an output valid/ready handshake toward the ALU result path.

Parameters:
- ACC_W, 10, accumulator/result width in bits; must be >= 8.
- COUNT, 4, products summed per batch; must be >= 1.
- CNT_W, $clog2(COUNT+1), width of the product counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort; discards the current batch.
- in_valid  input  1  product available on prod_lo/prod_hi.
- in_ready  output  1  block can accept a product this cycle.
- prod_lo  input  4  low nibble of the multiplier product.
- prod_hi  input  4  high nibble of the multiplier product.
- out_valid  output  1  batch result held stable on acc_out.
- out_ready  input  1  consumer accepts the result.
- acc_out  output  ACC_W  batch sum.
- ovf  output  1  an overflow occurred during this batch.
- cnt  output  CNT_W  products accepted in the current batch.

Behaviour:
- Reset (rst=1, asynchronous): state=ACCUM, acc_out=0, cnt=0, ovf=0, out_valid=0; in_ready=1 once rst deasserts.
- States: ACCUM and DONE.
  - in_ready = (state==ACCUM); combinational from state only.
  - out_valid = (state==DONE); registered.
- Product acceptance: a product is accepted when in_valid && in_ready. The product value is p = {prod_hi,prod_lo}, zero-extended to ACC_W+1 bits.
- On acceptance:
  - sum = acc_out + p.
  - acc_out <= sum[ACC_W-1:0].
  - If sum[ACC_W]=1, ovf <= 1; ovf is sticky within the batch.
  - cnt <= cnt + 1.
- ACCUM -> DONE when a product is accepted and cnt==COUNT-1. acc_out includes that product, and out_valid is high on the next cycle (latency 1 from the last accept).
- In DONE:
  - in_ready=0; the upstream producer must hold its data.
  - acc_out, ovf and cnt (==COUNT) stay stable until out_ready.
- DONE -> ACCUM on out_valid && out_ready. Same edge: acc_out<=0, cnt<=0, ovf<=0. A product cannot be accepted on that edge because in_ready=0.
- clr=1, any state: next edge gives ACCUM, acc_out=0, cnt=0, ovf=0, out_valid=0.
  - clr has priority over a simultaneous accept or out handshake.
  - A product presented with clr is dropped even though in_ready was 1.
- COUNT=1: every accepted product goes straight to DONE.
- in_valid while in DONE is ignored, with no state change.
- out_ready while in ACCUM is ignored.
- Reset asserted mid-batch: immediate return to reset values; the partial sum is lost.

Optional Feature:
- Macro: PROD_ACCUM_SAT_EN.
- Defined: on overflow, acc_out <= {ACC_W{1'b1}} and then stays saturated for the rest of the batch; ovf is set as normal.
- Undefined: the accumulator wraps modulo 2^ACC_W; ovf is set as normal.

Decomposition:
- Shared package holds:
  - state encoding: ACCUM=1'b0, DONE=1'b1.
  - PROD_W=8, the product width, and the nibble split constant 4.
- One sub-module, prod_accum_add: combinational ACC_W-bit adder with carry out. It performs saturation when PROD_ACCUM_SAT_EN is defined.
- Counter and FSM stay in prod_accum.

Test Plan:
- Reset/basic (defaults), out_ready=1: feed products 15*15 (hi=E, lo=1) four times back-to-back -> out_valid one cycle after the 4th accept, acc_out=900 (0x384), ovf=0, cnt=4; returns to ACCUM next cycle with acc_out=0.
- Backpressure, out_ready=0: feed 1*9, 3*7, 8*2, 0 -> acc_out=46, held stable; in_ready=0 and in_valid ignored for 5 cycles; raise out_ready -> one-cycle handshake, then cnt=0.
- Overflow (ACC_W=8, COUNT=2), feeding 225 then 225:
  - Macro undefined -> acc_out=194, ovf=1.
  - PROD_ACCUM_SAT_EN defined -> acc_out=255, ovf=1.
- clr mid-batch: after 2 accepts (5, 10), assert clr together with in_valid (p=15) -> acc_out=0, cnt=0, and the product is dropped. Then 4 products of 5 -> acc_out=20.
- Async reset: assert rst between clock edges while in DONE -> out_valid and acc_out go to 0 immediately, without waiting for a clock edge.
- Sweep: a=0..15 with b=5, grouped in batches of 4 -> batch sums 30, 110, 190, 270.
